// File: rtl/cart_mem_arbiter_if.sv
// Cartridge memory port bundle between the arbiter (master) and the memory controller (slave).
interface cart_mem_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_ack;
  logic [7:0]  mem_dout;

  modport master (output mem_req, mem_we, mem_addr, mem_din, input mem_ack, mem_dout);
  modport slave  (input mem_req, mem_we, mem_addr, mem_din, output mem_ack, mem_dout);
endinterface

// File: rtl/cart_mem_arbiter.sv
// Single-port cartridge memory arbiter: CHR > PRG > AUX fixed priority with an AUX starvation
// guard, one pending slot per requester, and a timeout abort on a silent memory controller.
module cart_mem_arbiter #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned AUX_STARVE = 63
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chr_req,
  input  logic               chr_we,
  input  logic [21:0]        chr_addr,
  input  logic [7:0]         chr_din,
  output logic               chr_ack,
  output logic [7:0]         chr_dout,
  input  logic               prg_req,
  input  logic               prg_we,
  input  logic [21:0]        prg_addr,
  input  logic [7:0]         prg_din,
  output logic               prg_ack,
  output logic [7:0]         prg_dout,
  input  logic               aux_req,
  input  logic               aux_we,
  input  logic [21:0]        aux_addr,
  input  logic [7:0]         aux_din,
  output logic               aux_ack,
  output logic [7:0]         aux_dout,
  cart_mem_arbiter_if.master mem,
  input  logic               status_clr,
  output logic [2:0]         overflow,
  output logic               timeout_err
);

  localparam int unsigned AW   = 22;
  localparam int unsigned DW   = 8;
  localparam int unsigned NREQ = 3;
  localparam int unsigned TW   = 8;
  localparam int unsigned SW   = 6;
  localparam logic [TW-1:0] TMO    = TW'(TIMEOUT);
  localparam logic [SW-1:0] STARVE = SW'(AUX_STARVE);
  localparam logic [1:0]    CHR = 2'd0;
  localparam logic [1:0]    PRG = 2'd1;
  localparam logic [1:0]    AUX = 2'd2;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [NREQ-1:0] in_req;
  logic [NREQ-1:0] in_we;
  logic [AW-1:0]   in_addr [NREQ];
  logic [DW-1:0]   in_din  [NREQ];

  state_t          state;
  logic [1:0]      owner;
  logic [TW-1:0]   tcnt;
  logic [SW-1:0]   aux_wait;
  logic [NREQ-1:0] slot_v;
  logic [NREQ-1:0] slot_we;
  logic [AW-1:0]   slot_addr [NREQ];
  logic [DW-1:0]   slot_din  [NREQ];
  logic [NREQ-1:0] ack;
  logic [DW-1:0]   dout [NREQ];

  logic            grant;
  logic            done;
  logic            expired;
  logic [1:0]      win;
  logic [NREQ-1:0] fin;
  logic [NREQ-1:0] ovf_set;

  assign in_req     = {aux_req, prg_req, chr_req};
  assign in_we      = {aux_we, prg_we, chr_we};
  assign in_addr[0] = chr_addr;
  assign in_addr[1] = prg_addr;
  assign in_addr[2] = aux_addr;
  assign in_din[0]  = chr_din;
  assign in_din[1]  = prg_din;
  assign in_din[2]  = aux_din;

  // Winner among pending slots; a starved AUX overrides the fixed order.
  always_comb begin
    win = CHR;
    if (slot_v[AUX] && aux_wait == STARVE) win = AUX;
    else if (slot_v[CHR])                  win = CHR;
    else if (slot_v[PRG])                  win = PRG;
    else if (slot_v[AUX])                  win = AUX;
  end

  assign grant   = (state == IDLE) && (|slot_v);
  assign done    = (state == BUSY) && (mem.mem_ack || tcnt == TMO);
  assign expired = (state == BUSY) && !mem.mem_ack && (tcnt == TMO);

  // Completion mask lets a same-cycle strobe refill the slot being retired.
  always_comb begin
    fin = '0;
    if (done) fin[owner] = 1'b1;
  end

  assign ovf_set = in_req & slot_v & ~fin;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= CHR;
      tcnt         <= '0;
      aux_wait     <= '0;
      slot_v       <= '0;
      slot_we      <= '0;
      ack          <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_we   <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_din  <= '0;
      overflow     <= '0;
      timeout_err  <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        slot_addr[i] <= '0;
        slot_din[i]  <= '0;
        dout[i]      <= '0;
      end
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (grant) begin
            state        <= BUSY;
            owner        <= win;
            tcnt         <= '0;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= slot_we[win];
            mem.mem_addr <= slot_addr[win];
            mem.mem_din  <= slot_din[win];
          end
        end
        BUSY: begin
          if (done) begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
            ack[owner]  <= 1'b1;
            if (!slot_we[owner]) dout[owner] <= mem.mem_ack ? mem.mem_dout : 8'hFF;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Saturating at the threshold keeps the equality test reachable for any AUX_STARVE.
      if (grant && win == AUX)
        aux_wait <= '0;
      else if (slot_v[AUX] && !(state == BUSY && owner == AUX) && aux_wait != STARVE)
        aux_wait <= aux_wait + SW'(1);

      for (int i = 0; i < NREQ; i++) begin
        if (in_req[i] && (!slot_v[i] || fin[i])) begin
          slot_v[i]    <= 1'b1;
          slot_we[i]   <= in_we[i];
          slot_addr[i] <= in_addr[i];
          slot_din[i]  <= in_din[i];
        end else if (fin[i]) begin
          slot_v[i] <= 1'b0;
        end
      end

      overflow    <= (status_clr ? 3'b000 : overflow) | ovf_set;
      timeout_err <= (status_clr ? 1'b0 : timeout_err) | expired;
    end
  end

  assign chr_ack  = ack[0];
  assign prg_ack  = ack[1];
  assign aux_ack  = ack[2];
  assign chr_dout = dout[0];
  assign prg_dout = dout[1];
  assign aux_dout = dout[2];

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Self-checking bench for cart_mem_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a slot/queue-level reference model of the arbitration rules.
module tb_cart_mem_arbiter;

  localparam int TIMEOUT    = 255;
  localparam int AUX_STARVE = 63;

  logic clk;
  logic reset;
  logic status_clr;
  logic [2:0]  overflow;
  logic        timeout_err;
  logic        chr_ack, prg_ack, aux_ack;
  logic [7:0]  chr_dout, prg_dout, aux_dout;

  logic [2:0]  s_req;
  logic [2:0]  s_we;
  logic [21:0] s_addr [3];
  logic [7:0]  s_din  [3];
  logic        s_rst;
  logic        s_clr;

  cart_mem_arbiter_if mif ();

  cart_mem_arbiter #(.TIMEOUT(TIMEOUT), .AUX_STARVE(AUX_STARVE)) dut (
    .clk        (clk),
    .reset      (reset),
    .chr_req    (s_req[0]),
    .chr_we     (s_we[0]),
    .chr_addr   (s_addr[0]),
    .chr_din    (s_din[0]),
    .chr_ack    (chr_ack),
    .chr_dout   (chr_dout),
    .prg_req    (s_req[1]),
    .prg_we     (s_we[1]),
    .prg_addr   (s_addr[1]),
    .prg_din    (s_din[1]),
    .prg_ack    (prg_ack),
    .prg_dout   (prg_dout),
    .aux_req    (s_req[2]),
    .aux_we     (s_we[2]),
    .aux_addr   (s_addr[2]),
    .aux_din    (s_din[2]),
    .aux_ack    (aux_ack),
    .aux_dout   (aux_dout),
    .mem        (mif),
    .status_clr (status_clr),
    .overflow   (overflow),
    .timeout_err(timeout_err)
  );

  assign reset      = s_rst;
  assign status_clr = s_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: one pending slot per requester, current owner index (-1 = idle).
  logic [2:0]  m_v, m_we, m_ack, m_ovf;
  logic [21:0] m_addr [3];
  logic [7:0]  m_din  [3];
  logic [7:0]  m_dout [3];
  int          m_owner, m_t, m_aw;
  logic        m_mreq, m_mwe, m_terr;
  logic [21:0] m_maddr;
  logic [7:0]  m_mdin;

  // Memory controller behaviour knobs.
  bit   rand_mode = 0;
  bit   never_ack = 0;
  bit   restrobe  = 0;
  int   fix_delay = 0;
  logic [7:0] fix_data = 8'h00;
  int   resp_cnt   = 0;
  int   resp_delay = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_v = '0; m_we = '0; m_ack = '0; m_ovf = '0; m_terr = 1'b0;
    m_owner = -1; m_t = 0; m_aw = 0;
    m_mreq = 1'b0; m_mwe = 1'b0; m_maddr = '0; m_mdin = '0;
    for (int i = 0; i < 3; i++) begin
      m_addr[i] = '0; m_din[i] = '0; m_dout[i] = '0;
    end
  endtask

  task automatic model_step();
    int fin, w, prev_owner;
    if (s_rst) begin
      model_reset();
      return;
    end
    prev_owner = m_owner;
    fin = -1;
    w = -1;
    m_ack = '0;
    if (prev_owner < 0) begin
      if (m_v[2] && m_aw == AUX_STARVE) w = 2;
      else for (int i = 0; i < 3; i++) if (w < 0 && m_v[i]) w = i;
    end
    if (w == 2) m_aw = 0;
    else if (m_v[2] && prev_owner != 2 && m_aw < AUX_STARVE) m_aw++;
    if (prev_owner >= 0) begin
      if (mif.mem_ack || m_t == TIMEOUT) begin
        fin = prev_owner;
        m_ack[fin] = 1'b1;
        if (!m_we[fin]) m_dout[fin] = mif.mem_ack ? mif.mem_dout : 8'hFF;
        m_mreq = 1'b0;
        m_owner = -1;
      end else begin
        m_t++;
      end
    end else if (w >= 0) begin
      m_owner = w;
      m_mreq = 1'b1;
      m_mwe = m_we[w];
      m_maddr = m_addr[w];
      m_mdin = m_din[w];
      m_t = 0;
    end
    if (s_clr) begin
      m_ovf = '0;
      m_terr = 1'b0;
    end
    if (fin >= 0 && !mif.mem_ack) m_terr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (s_req[i]) begin
        if (!m_v[i] || fin == i) begin
          m_v[i] = 1'b1; m_we[i] = s_we[i]; m_addr[i] = s_addr[i]; m_din[i] = s_din[i];
        end else begin
          m_ovf[i] = 1'b1;
        end
      end else if (fin == i) begin
        m_v[i] = 1'b0;
      end
    end
  endtask

  task automatic respond();
    if (mif.mem_req && !never_ack) begin
      if (resp_cnt >= resp_delay) begin
        mif.mem_ack = 1'b1;
        mif.mem_dout = rand_mode ? 8'($urandom) : fix_data;
        resp_cnt = 0;
        if (restrobe && m_owner == 0) begin
          s_req[0] = 1'b1;
          s_we[0] = 1'b0;
          s_addr[0] = 22'($urandom);
        end
      end else begin
        mif.mem_ack = 1'b0;
        resp_cnt++;
      end
    end else begin
      mif.mem_ack = rand_mode && !mif.mem_req && ($urandom_range(0, 7) == 0);
      mif.mem_dout = 8'($urandom);
      resp_cnt = 0;
      if (rand_mode) resp_delay = ($urandom_range(0, 39) == 0) ? 300 : int'($urandom_range(0, 3));
      else resp_delay = fix_delay;
    end
  endtask

  // One clock: model advances on the edge, outputs compared and inputs updated mid-cycle.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    s_req = '0;
    s_rst = 1'b0;
    s_clr = 1'b0;
    check_eq("acks", 64'({aux_ack, prg_ack, chr_ack}), 64'(m_ack));
    check_eq("douts", 64'({aux_dout, prg_dout, chr_dout}), 64'({m_dout[2], m_dout[1], m_dout[0]}));
    check_eq("mem_bus", 64'({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_din}),
             64'({m_mreq, m_mwe, m_maddr, m_mdin}));
    check_eq("status", 64'({overflow, timeout_err}), 64'({m_ovf, m_terr}));
    respond();
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && (mif.mem_req || m_v != 3'b000); k++) cycle();
    check_eq("drain_idle", 64'({mif.mem_req, m_v}), 64'(0));
    cycle();
  endtask

  task automatic strobe(input int i, input logic we, input logic [21:0] addr, input logic [7:0] din);
    s_req[i] = 1'b1;
    s_we[i] = we;
    s_addr[i] = addr;
    s_din[i] = din;
  endtask

  int c_chr, c_prg, c_aux, g, n_chr;
  bit seen;

  initial begin
    s_req = '0; s_we = '0; s_rst = 1'b1; s_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin s_addr[i] = '0; s_din[i] = '0; end
    mif.mem_ack = 1'b0; mif.mem_dout = 8'h00;
    model_reset();

    // Reset state.
    cycle();
    s_rst = 1'b1;
    cycle();
    check_eq("rst_ctrl", 64'({chr_ack, prg_ack, aux_ack, overflow, timeout_err, mif.mem_req, mif.mem_we}), 64'(0));
    check_eq("rst_bus", 64'({mif.mem_addr, mif.mem_din}), 64'(0));
    check_eq("rst_douts", 64'({aux_dout, prg_dout, chr_dout}), 64'(0));
    cycle();

    // Single PRG read at minimum latency.
    fix_delay = 0; fix_data = 8'h5A;
    resp_delay = 0;
    strobe(1, 1'b0, 22'h00A123, 8'h00);
    cycle();
    check_eq("prg_not_yet", 64'(mif.mem_req), 64'(0));
    cycle();
    check_eq("prg_grant", 64'({mif.mem_req, mif.mem_addr}), 64'({1'b1, 22'h00A123}));
    cycle();
    check_eq("prg_ack_only", 64'({aux_ack, prg_ack, chr_ack}), 64'(3'b010));
    check_eq("prg_dout", 64'(prg_dout), 64'(8'h5A));
    check_eq("prg_req_drop", 64'(mif.mem_req), 64'(0));
    drain();

    // Simultaneous strobes, controller acks one cycle after each mem_req rise.
    fix_delay = 1; fix_data = 8'hC3;
    strobe(0, 1'b0, 22'h100001, 8'h00);
    strobe(1, 1'b0, 22'h200002, 8'h00);
    strobe(2, 1'b0, 22'h300003, 8'h00);
    c_chr = -1; c_prg = -1; c_aux = -1;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (chr_ack && c_chr < 0) c_chr = cyc;
      if (prg_ack && c_prg < 0) c_prg = cyc;
      if (aux_ack && c_aux < 0) c_aux = cyc;
    end
    check_eq("sim_all_acked", 64'({c_chr >= 0, c_prg >= 0, c_aux >= 0}), 64'(3'b111));
    check_eq("sim_prg_after_chr", 64'(c_prg - c_chr), 64'(3));
    check_eq("sim_aux_after_prg", 64'(c_aux - c_prg), 64'(3));
    drain();

    // AUX starvation under continuous CHR traffic.
    fix_delay = 0; restrobe = 1;
    strobe(0, 1'b0, 22'h012345, 8'h00);
    strobe(2, 1'b0, 22'h3F0000, 8'h00);
    n_chr = 0; seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      cycle();
      if (chr_ack) n_chr++;
      if (aux_ack) seen = 1;
    end
    check_eq("starve_aux_served", 64'(seen), 64'(1));
    check_eq("starve_chr_count", 64'(n_chr), 64'(32));
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cycle();
      if (chr_ack) seen = 1;
    end
    check_eq("starve_chr_resume", 64'(seen), 64'(1));
    restrobe = 0;
    drain();

    // Overflow on a second PRG strobe while the first is pending.
    fix_delay = 2; fix_data = 8'h11;
    s_clr = 1'b1;
    cycle();
    strobe(1, 1'b0, 22'h001111, 8'h00);
    cycle();
    strobe(1, 1'b0, 22'h002222, 8'h00);
    cycle();
    check_eq("ovf_first_addr", 64'(mif.mem_addr), 64'(22'h001111));
    check_eq("ovf_bits", 64'(overflow), 64'(3'b010));
    drain();
    s_clr = 1'b1;
    cycle();
    check_eq("ovf_cleared", 64'(overflow), 64'(0));

    // Timeout on an AUX read that the controller never acknowledges.
    never_ack = 1;
    strobe(2, 1'b0, 22'h2ABCDE, 8'h00);
    cycle();
    cycle();
    check_eq("tmo_grant", 64'(mif.mem_req), 64'(1));
    g = cyc; seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      cycle();
      if (aux_ack) seen = 1;
    end
    check_eq("tmo_latency", 64'(cyc - g), 64'(256));
    check_eq("tmo_dout", 64'(aux_dout), 64'(8'hFF));
    check_eq("tmo_flags", 64'({timeout_err, mif.mem_req}), 64'(2'b10));
    never_ack = 0;
    drain();

    // Reset in the middle of a CHR access, then a normal access.
    never_ack = 1;
    strobe(0, 1'b0, 22'h155555, 8'h00);
    cycle(); cycle(); cycle();
    s_rst = 1'b1;
    cycle();
    check_eq("midrst_ctrl", 64'({chr_ack, prg_ack, aux_ack, overflow, timeout_err, mif.mem_req, mif.mem_we}), 64'(0));
    check_eq("midrst_bus", 64'({mif.mem_addr, mif.mem_din}), 64'(0));
    check_eq("midrst_douts", 64'({aux_dout, prg_dout, chr_dout}), 64'(0));
    never_ack = 0; fix_delay = 1; fix_data = 8'h3C;
    cycle();
    strobe(0, 1'b0, 22'h3ABCDE, 8'h00);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      if (chr_ack) seen = 1;
    end
    check_eq("post_rst_ack", 64'(seen), 64'(1));
    check_eq("post_rst_dout", 64'(chr_dout), 64'(8'h3C));
    drain();

    // Randomized traffic against the model.
    rand_mode = 1;
    for (int k = 0; k < 2500; k++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 5) == 0) strobe(i, 1'($urandom), 22'($urandom), 8'($urandom));
      s_clr = ($urandom_range(0, 24) == 0);
      s_rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rand_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
